x_mem_access_unit: RTL

//  Data-memory side of the controller's MemRead/MemWrite encoding (000 none, 001 byte, 011 half, 111 word).

---
 rtl/x_mem_pkg.sv | 21 ++
 rtl/x_mem_lane_align.sv | 58 +++++
 rtl/x_mem_access_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/x_mem_pkg.sv
// Shared definitions for the data-memory access unit: size codes, FSM states, writeback select.
package x_mem_pkg;

  localparam logic [2:0] SZ_NONE = 3'b000;
  localparam logic [2:0] SZ_B    = 3'b001;
  localparam logic [2:0] SZ_H    = 3'b011;
  localparam logic [2:0] SZ_W    = 3'b111;

  localparam logic [1:0] WB_MEM  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic size_legal(input logic [2:0] c);
    return (c == SZ_B) || (c == SZ_H) || (c == SZ_W);
  endfunction

endpackage

// File: rtl/x_mem_lane_align.sv
// Combinational byte-lane steering for stores and lane extract / sign-zero extension for loads.
// Sub-alignment address bits are masked: halves use a[1] only, words always use lane 0.
module x_mem_lane_align
  import x_mem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  a_lo,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [1:0]  lane;
  logic [31:0] repl;
  logic [31:0] shifted;

  always_comb begin
    lane        = 2'b00;
    be          = 4'b0000;
    repl        = wdata;
    wdata_lanes = 32'h0;
    rdata_ext   = 32'h0;
    case (size)
      SZ_B: begin
        lane = a_lo;
        be   = 4'b0001 << a_lo;
        repl = {4{wdata[7:0]}};
      end
      SZ_H: begin
        lane = {a_lo[1], 1'b0};
        be   = 4'b0011 << lane;
        repl = {2{wdata[15:0]}};
      end
      SZ_W: begin
        lane = 2'b00;
        be   = 4'b1111;
        repl = wdata;
      end
      default: ;
    endcase

    // Unselected lanes are driven to zero so the bus never sees stale store bytes.
    for (int i = 0; i < 4; i++) begin
      wdata_lanes[8*i +: 8] = be[i] ? repl[8*i +: 8] : 8'h00;
    end

    shifted = word >> {lane, 3'b000};
    case (size)
      SZ_B:    rdata_ext = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    rdata_ext = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/x_mem_access_unit.sv
// Load/store unit: one single-word bus transaction per instruction, with stall, timeout and error.
// Optional macro XMAU_MISALIGN_TRAP_EN: misaligned half/word accesses abort with err instead of masking.
module x_mem_access_unit
  import x_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  MemRead,
  input  logic [2:0]  MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nx;
  logic [7:0]  tmo_cnt;
  logic [2:0]  code;
  logic [2:0]  sz_q;
  logic [1:0]  alo_q;
  logic        uns_q;
  logic        req_any, misalign, bad_req, start, tmo_hit;
  logic [2:0]  al_size;
  logic [1:0]  al_lo;
  logic        al_uns;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;
  logic        unused_funct;

  assign unused_funct = ^Funct3[1:0];

  assign code    = MemRead | MemWrite;
  assign req_any = req_valid && (code != SZ_NONE);
  assign stall   = req_any && (state != ST_DONE);
  assign done    = (state == ST_DONE);
  assign tmo_hit = (tmo_cnt == TMO_LAST);
  assign dbg_state = state;

`ifdef XMAU_MISALIGN_TRAP_EN
  assign misalign = ((code == SZ_H) && addr[0]) || ((code == SZ_W) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign bad_req = ((MemRead != SZ_NONE) && (MemWrite != SZ_NONE)) || !size_legal(code) || misalign;

  // While on the bus the latched access shape drives the load extract; otherwise the live request.
  assign al_size = (state == ST_BUS) ? sz_q  : code;
  assign al_lo   = (state == ST_BUS) ? alo_q : addr[1:0];
  assign al_uns  = (state == ST_BUS) ? uns_q : Funct3[2];

  x_mem_lane_align u_align (
    .size        (al_size),
    .a_lo        (al_lo),
    .uns         (al_uns),
    .wdata       (wdata),
    .word        (bus_rdata),
    .be          (al_be),
    .wdata_lanes (al_wdata),
    .rdata_ext   (al_rdata)
  );

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_any) begin
          if (bad_req) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_BUS;
            start    = 1'b1;
          end
        end
      end
      ST_BUS:  if (bus_ack || tmo_hit) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt   <= 8'h0;
      err       <= 1'b0;
      rdata     <= 32'h0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= 4'h0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      sz_q      <= SZ_NONE;
      alo_q     <= 2'b00;
      uns_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tmo_cnt <= 8'h0;
          err     <= 1'b0;
          if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= (MemWrite != SZ_NONE);
            bus_be    <= al_be;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= al_wdata;
            sz_q      <= code;
            alo_q     <= addr[1:0];
            uns_q     <= Funct3[2];
          end else if (req_any) begin
            err   <= 1'b1;
            rdata <= 32'h0;
          end
        end
        ST_BUS: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            rdata   <= al_rdata;
          end else if (tmo_hit) begin
            bus_req <= 1'b0;
            err     <= 1'b1;
            rdata   <= 32'h0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'h1;
          end
        end
        default: err <= 1'b0;
      endcase
    end
  end

endmodule
